fast_pulse_stretch: RTL and testbench
=====================================

# fast_pulse_stretch

Transmit end of the single-bit crossing from the fast domain into the slow domain. Converts single-cycle `pulse_in` events on `clk_fast` into a registered level pulse on `out`. Each `out` high period is held long enough for the slow-domain two-flop synchronizer to capture it, and is followed by a guaranteed low gap. Events that arrive while a pulse is in flight are counted and replayed, so the slow-domain edge detector sees exactly one rising edge per `pulse_in` event.

## Interface
- `HOLD_CYCLES`, default 4: `clk_fast` cycles that `out` stays high, and also the length of the mandatory low gap. Legal range is 2 or more. Must be at least (slow period / fast period) + 1.
- `PEND_W`, default 4: width of the pending-event counter. Capacity is 2^PEND_W − 1 queued events.
- `clk_fast` input, 1 bit: the only clock. All logic is on its rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `pulse_in` input, 1 bit: event strobe. Each cycle it is sampled high counts as one event.
- `out` output, 1 bit: registered stretched pulse toward the slow domain. Driven directly from a flop, with no combinational path from any input.
- `busy` output, 1 bit: high whenever the FSM is not in IDLE.
- `pend_cnt` output, PEND_W bits: number of queued events not yet emitted.
- `overflow` output, 1 bit: sticky flag. Set when an event arrives while `pend_cnt` is saturated.

## Operation
- FSM states:
  - IDLE: `out`=0.
  - HIGH: `out`=1.
  - GAP: `out`=0.
- Hold counter `hcnt` has width $clog2(HOLD_CYCLES+1). It is loaded with HOLD_CYCLES−1 on entry to HIGH or GAP and decrements every cycle.
- IDLE:
  - `pulse_in`=1 → HIGH.
  - Otherwise stay in IDLE.
- HIGH:
  - `hcnt`≠0 → decrement `hcnt`.
  - `hcnt`=0 → GAP.
- GAP:
  - `hcnt`≠0 → decrement `hcnt`.
  - `hcnt`=0 and `pend_cnt`>0 → HIGH, and `pend_cnt` decrements.
  - `hcnt`=0 and `pend_cnt`=0 → IDLE.
- Queueing: `pulse_in`=1 in HIGH or GAP increments `pend_cnt`.
- Simultaneous event and consume (`pulse_in`=1 in the GAP exit cycle with `pend_cnt`>0): `pend_cnt` is unchanged and the FSM enters HIGH.
- `pulse_in`=1 in the GAP exit cycle with `pend_cnt`=0: the FSM goes directly to HIGH and `pend_cnt` stays 0. The event is not lost.
- Saturation: `pulse_in`=1 while `pend_cnt`=2^PEND_W−1 and no consume occurs that cycle:
  - the event is dropped;
  - `pend_cnt` holds;
  - `overflow` is set.
  - `pend_cnt` never wraps.
- `overflow` stays set until reset.
- IDLE with `pend_cnt`>0 is unreachable. The GAP exit always consumes queued events first.

## Timing
- Reset values:
  - `out`=0
  - `busy`=0
  - `pend_cnt`=0
  - `overflow`=0
  - FSM state = IDLE
  - `hcnt`=0
- Reset takes effect immediately on `rst_n` falling, at any point in operation. Queued events are discarded.
- Latency: `pulse_in` sampled high at edge T in IDLE → `out` and `busy` are 1 after edge T.
- `out` is high for exactly HOLD_CYCLES cycles, then low for exactly HOLD_CYCLES cycles.
- Back-to-back queued events repeat with a period of exactly 2·HOLD_CYCLES cycles.
- `busy` falls at the edge where GAP exits to IDLE. From that cycle on, a new `pulse_in` starts a HIGH period with the same one-cycle latency.
- `pend_cnt` updates at the edge that samples `pulse_in`.
- Minimum spacing between `out` rising edges is 2·HOLD_CYCLES.

## Configuration
- Macro: `FAST_PULSE_STRETCH_OVERFLOW_EN`.
- Defined: the `overflow` flop and its saturation detection are compiled in, with the behaviour described above.
- Undefined:
  - `overflow` is tied to 0 and no flop is generated;
  - saturated events are still dropped silently and `pend_cnt` still never wraps;
  - all other behaviour is identical.

## Test plan
All scenarios use HOLD_CYCLES=4 and PEND_W=2.

- Single pulse: `pulse_in` high for one cycle at cycle 10 → `out` is 1 in cycles 11–14 and 0 from cycle 15; `busy` is 1 in cycles 11–18; `pend_cnt` stays 0.
- Burst: `pulse_in` high for 3 consecutive cycles from cycle 10 → `pend_cnt` is 2 after cycle 12; `out` shows three 4-high/4-low pulses starting at cycles 11, 19 and 27; `busy` falls after cycle 34.
- Coincident event at GAP exit: extra `pulse_in` on the final GAP cycle with `pend_cnt`=1 → `pend_cnt` stays 1 and `out` rises on the next cycle.
- Overflow, with macro defined: 5 pulses on consecutive cycles → `pend_cnt` saturates at 3, `overflow`=1, exactly 4 `out` pulses, `overflow` stays 1. With macro undefined: same stimulus gives `overflow`=0 and 4 pulses.
- Reset mid-operation: assert `rst_n`=0 during the second cycle of HIGH with `pend_cnt`=2 → `out`, `busy` and `pend_cnt` are 0 immediately, without waiting for a clock edge; after release, one new `pulse_in` gives exactly one 4-cycle pulse.
- Slow-domain check: connect to the slow-domain edge-detect synchronizer with clk_slow = clk_fast/3 → exactly one slow-side `out` pulse per `pulse_in` event, across 100 random event patterns with no overflow.

Source files
------------

// File: rtl/fast_pulse_stretch.sv
// Fast-side pulse stretcher: turns clk_fast strobes into held level pulses with replay queue.
// Optional sticky overflow flag compiled in with FAST_PULSE_STRETCH_OVERFLOW_EN.
module fast_pulse_stretch #(
    parameter int HOLD_CYCLES = 4,
    parameter int PEND_W      = 4
) (
    input  logic              clk_fast,
    input  logic              rst_n,
    input  logic              pulse_in,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow
);
    localparam int              HW    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0]   HLOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [PEND_W-1:0] PMAX = '1;

    typedef enum logic [1:0] {IDLE, HIGH, GAP} state_t;

    state_t            state, state_nxt;
    logic [HW-1:0]     hcnt, hcnt_nxt;
    logic [PEND_W-1:0] pend_nxt;
    logic              gap_exit, consume, enq, sat;

    always_comb begin
        state_nxt = state;
        hcnt_nxt  = hcnt;
        gap_exit  = 1'b0;
        case (state)
            IDLE: begin
                if (pulse_in) begin
                    state_nxt = HIGH;
                    hcnt_nxt  = HLOAD;
                end
            end
            HIGH: begin
                if (hcnt != '0) begin
                    hcnt_nxt = hcnt - HW'(1);
                end else begin
                    state_nxt = GAP;
                    hcnt_nxt  = HLOAD;
                end
            end
            GAP: begin
                if (hcnt != '0) begin
                    hcnt_nxt = hcnt - HW'(1);
                end else begin
                    gap_exit = 1'b1;
                    // An event landing on the exit cycle launches directly
                    if (pend_cnt != '0 || pulse_in) begin
                        state_nxt = HIGH;
                        hcnt_nxt  = HLOAD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                hcnt_nxt  = '0;
            end
        endcase

        consume  = gap_exit && (pend_cnt != '0);
        enq      = pulse_in && (state != IDLE) && !gap_exit;
        sat      = enq && (pend_cnt == PMAX);
        pend_nxt = pend_cnt;
        if (consume && !pulse_in)
            pend_nxt = pend_cnt - PEND_W'(1);
        else if (enq && !sat)
            pend_nxt = pend_cnt + PEND_W'(1);
    end

    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hcnt     <= '0;
            pend_cnt <= '0;
            out      <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            hcnt     <= hcnt_nxt;
            pend_cnt <= pend_nxt;
            out      <= (state_nxt == HIGH);
            busy     <= (state_nxt != IDLE);
        end
    end

`ifdef FAST_PULSE_STRETCH_OVERFLOW_EN
    always_ff @(posedge clk_fast or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (sat)
            overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_fast_pulse_stretch.sv
// Directed + random bench for fast_pulse_stretch (HOLD_CYCLES=4, PEND_W=2) with a slow-side synchronizer.
module tb_fast_pulse_stretch;
    localparam int HOLD = 4;
    localparam int PW   = 2;
`ifdef FAST_PULSE_STRETCH_OVERFLOW_EN
    localparam logic EXP_OVF = 1'b1;
`else
    localparam logic EXP_OVF = 1'b0;
`endif

    logic          clk_fast = 1'b0;
    logic          clk_slow = 1'b0;
    logic          rst_n    = 1'b0;
    logic          pulse_in = 1'b0;
    logic          out, busy, overflow;
    logic [PW-1:0] pend_cnt;

    fast_pulse_stretch #(.HOLD_CYCLES(HOLD), .PEND_W(PW)) dut (
        .clk_fast(clk_fast), .rst_n(rst_n), .pulse_in(pulse_in),
        .out(out), .busy(busy), .pend_cnt(pend_cnt), .overflow(overflow)
    );

    always #5  clk_fast = ~clk_fast;
    always #15 clk_slow = ~clk_slow;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_rise[$];
    int exp_n[$];
    bit chk_rise = 1'b1;
    int rise_cnt = 0;
    int slow_cnt = 0;

    always @(posedge clk_fast) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Slow-domain two-flop synchronizer plus rising-edge detector
    logic s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    always @(posedge clk_slow) begin
        s1 <= out;
        s2 <= s1;
        s3 <= s2;
        if (s2 && !s3) slow_cnt <= slow_cnt + 1;
    end

    // Output monitor: pops expected rise cycles, checks high width and low gap
    bit prev = 1'b0, seen_fall = 1'b0;
    int hi_len = 0, lo_len = 0;
    always @(negedge clk_fast) begin
        if (!rst_n) begin
            prev = 1'b0; seen_fall = 1'b0; hi_len = 0; lo_len = 0;
        end else begin
            if (out && !prev) begin
                rise_cnt++;
                if (seen_fall) check("low_gap_min", 32'(lo_len >= HOLD), 1);
                if (chk_rise) begin
                    if (exp_rise.size() == 0) check("rise_expected", 0, 1);
                    else check("rise_cycle", cyc, exp_rise.pop_front());
                end
            end
            if (out) begin
                hi_len = prev ? hi_len + 1 : 1;
            end else if (prev) begin
                check("high_width", hi_len, HOLD);
                seen_fall = 1'b1;
                lo_len = 1;
            end else begin
                lo_len++;
            end
            prev = out;
        end
    end

    task automatic nedge();
        @(negedge clk_fast);
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && busy; i++) nedge();
        check("idle_timeout", busy, 0);
    endtask

    task automatic do_reset();
        nedge();
        rst_n = 1'b0;
        nedge();
        nedge();
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, r0, s0, n;

        // Reset state
        #2;
        check("rst_out", out, 0);
        check("rst_busy", busy, 0);
        check("rst_pend", pend_cnt, 0);
        check("rst_ovf", overflow, 0);
        repeat (3) nedge();
        rst_n = 1'b1;
        repeat (5) nedge();

        // Single pulse
        t0 = cyc; pulse_in = 1'b1; exp_rise.push_back(t0 + 1);
        for (int k = 1; k <= 10; k++) begin
            nedge();
            pulse_in = 1'b0;
            check("single_out", out, 32'(k <= HOLD));
            check("single_busy", busy, 32'(k <= 2 * HOLD));
            check("single_pend", pend_cnt, 0);
        end
        repeat (3) nedge();

        // Burst of three
        t0 = cyc; pulse_in = 1'b1;
        exp_rise.push_back(t0 + 1); exp_rise.push_back(t0 + 9); exp_rise.push_back(t0 + 17);
        nedge(); nedge(); nedge();
        pulse_in = 1'b0;
        check("burst_pend2", pend_cnt, 2);
        wait_idle(100);
        check("burst_busy_fall", cyc, t0 + 25);
        check("burst_pend0", pend_cnt, 0);
        check("burst_rises_left", exp_rise.size(), 0);
        repeat (3) nedge();

        // Coincident event on final GAP cycle with one queued
        t0 = cyc; pulse_in = 1'b1; exp_rise.push_back(t0 + 1);
        nedge();
        nedge();
        pulse_in = 1'b0;
        while (cyc < t0 + 8) nedge();
        pulse_in = 1'b1; exp_rise.push_back(t0 + 9); exp_rise.push_back(t0 + 17);
        nedge();
        pulse_in = 1'b0;
        check("coinc_pend", pend_cnt, 1);
        check("coinc_out", out, 1);
        wait_idle(100);
        check("coinc_pend0", pend_cnt, 0);
        check("coinc_rises_left", exp_rise.size(), 0);
        repeat (3) nedge();

        // Overflow: five back-to-back events, capacity three queued
        r0 = rise_cnt;
        t0 = cyc; pulse_in = 1'b1;
        for (int k = 0; k < 4; k++) exp_rise.push_back(t0 + 1 + 8 * k);
        repeat (5) nedge();
        pulse_in = 1'b0;
        check("ovf_pend_sat", pend_cnt, 3);
        check("ovf_flag", overflow, EXP_OVF);
        wait_idle(200);
        check("ovf_pulse_count", rise_cnt - r0, 4);
        check("ovf_sticky", overflow, EXP_OVF);
        check("ovf_rises_left", exp_rise.size(), 0);
        repeat (3) nedge();

        // Reset during second HIGH cycle of a replayed pulse, pend_cnt=2
        t0 = cyc; pulse_in = 1'b1;
        exp_rise.push_back(t0 + 1); exp_rise.push_back(t0 + 9);
        repeat (4) nedge();
        pulse_in = 1'b0;
        while (cyc < t0 + 10) nedge();
        check("mid_pend_pre", pend_cnt, 2);
        check("mid_out_pre", out, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out", out, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_pend", pend_cnt, 0);
        check("mid_rst_ovf", overflow, 0);
        nedge(); nedge();
        rst_n = 1'b1;
        repeat (2) nedge();
        r0 = rise_cnt;
        t0 = cyc; pulse_in = 1'b1; exp_rise.push_back(t0 + 1);
        nedge();
        pulse_in = 1'b0;
        wait_idle(100);
        repeat (20) nedge();
        check("post_rst_pulses", rise_cnt - r0, 1);
        check("post_rst_rises_left", exp_rise.size(), 0);

        // Slow-domain capture across random patterns
        do_reset();
        chk_rise = 1'b0;
        repeat (12) nedge();
        for (int p = 0; p < 100; p++) begin
            s0 = slow_cnt;
            n  = $urandom_range(1, 4);
            exp_n.push_back(n);
            for (int e = 0; e < n; e++) begin
                pulse_in = 1'b1;
                nedge();
                pulse_in = 1'b0;
                repeat ($urandom_range(0, 3)) nedge();
            end
            wait_idle(200);
            repeat (12) nedge();
            check("slow_pulse_count", slow_cnt - s0, exp_n.pop_front());
        end
        check("slow_no_ovf", overflow, 0);
        check("slow_pend0", pend_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
